carbon_mode_tier_ctrl: RTL

Tier and mode-stack controller inside the CarbonZ80 CPU core. It sits directly downstream of instruction decode/execute. It accepts MODEUP and RETMD requests, validates the target tier, and keeps the current tier CSR and a mode-descriptor LIFO (previous tier plus return PC). It returns either a completion response or a trap cause to the execute/trap stage. Its tier and stack-pointer outputs are the architectural tier CSR and the mode-stack depth that the tier testbench checks.

---
 rtl/carbon_arch_pkg.sv | 30 +++
 rtl/carbon_mode_tier_ctrl_if.sv | 25 ++
 rtl/carbon_mode_stack.sv | 62 ++++++
 rtl/carbon_mode_tier_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/carbon_arch_pkg.sv
// Shared architectural constants and types for the CarbonZ80 tier/mode-stack logic.
package carbon_arch_pkg;

  localparam logic [7:0] CARBON_Z80_DERIVED_TIER_P0_I8080 = 8'd0;
  localparam logic [7:0] CARBON_Z80_DERIVED_TIER_P1_I8085 = 8'd1;
  localparam logic [7:0] CARBON_Z80_DERIVED_TIER_P2_Z80   = 8'd2;

  localparam logic [31:0] CARBON_CAUSE_MODEUP_INVALID      = 32'h0000_0012;
  localparam logic [31:0] CARBON_CAUSE_MODESTACK_OVERFLOW  = 32'h0000_0013;
  localparam logic [31:0] CARBON_CAUSE_RETMD_UNDERFLOW     = 32'h0000_0014;

  localparam int CARBON_PC_W = 16;

  typedef enum logic {
    MD_MODEUP = 1'b0,
    MD_RETMD  = 1'b1
  } carbon_md_op_e;

  typedef struct packed {
    logic [7:0]             tier;
    logic [CARBON_PC_W-1:0] pc;
  } carbon_md_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } carbon_md_state_e;

endpackage

// File: rtl/carbon_mode_tier_ctrl_if.sv
// Request/response channel between execute and the tier controller.
interface carbon_mode_tier_ctrl_if #(
  parameter int PC_W = 16
);
  logic            req_valid;
  logic            req_ready;
  logic            req_op;
  logic [7:0]      req_tier;
  logic [PC_W-1:0] req_ret_pc;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_ok;
  logic [PC_W-1:0] rsp_pc;
  logic [31:0]     rsp_cause;

  modport master (
    output req_valid, req_op, req_tier, req_ret_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_ok, rsp_pc, rsp_cause
  );

  modport slave (
    input  req_valid, req_op, req_tier, req_ret_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_ok, rsp_pc, rsp_cause
  );
endinterface

// File: rtl/carbon_mode_stack.sv
// DEPTH-entry LIFO of {previous tier, return PC} with a registered top entry,
// so the controller can read the entry to restore without a memory read path.
module carbon_mode_stack #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 push_tier,
  input  logic [PC_W-1:0]            push_pc,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic [7:0]                 top_tier,
  output logic [PC_W-1:0]            top_pc
);
  localparam int SP_W  = $clog2(DEPTH+1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]      tier_mem [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic            do_push;
  logic            do_pop;

  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Stack pointer: saturates at both ends, never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + SP_W'(1);
    end else if (do_pop) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Entry storage: written at the current pointer on push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      tier_mem[IDX_W'(sp)] <= push_tier;
      pc_mem[IDX_W'(sp)]   <= push_pc;
    end
  end

  // Top-of-stack copy: follows a push directly, or reloads the entry below on pop.
  always_ff @(posedge clk) begin
    if (do_push) begin
      top_tier <= push_tier;
      top_pc   <= push_pc;
    end else if (do_pop && (sp > SP_W'(1))) begin
      top_tier <= tier_mem[IDX_W'(sp - SP_W'(2))];
      top_pc   <= pc_mem[IDX_W'(sp - SP_W'(2))];
    end
  end

endmodule

// File: rtl/carbon_mode_tier_ctrl.sv
// Tier CSR and mode-stack controller: accepts MODEUP/RETMD, validates the
// target tier, updates tier and LIFO, and returns completion or trap cause.
module carbon_mode_tier_ctrl
  import carbon_arch_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MAX_TIER   = 2,
  parameter int RESET_TIER = 0,
  parameter int PC_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  carbon_mode_tier_ctrl_if.slave     bus,
  output logic [7:0]                 tier_o,
  output logic [$clog2(DEPTH+1)-1:0] md_sp_o
);
  localparam int SP_W = $clog2(DEPTH+1);

  carbon_md_state_e state, state_nxt;

  carbon_md_op_e   op_q;
  logic [7:0]      tier_q;
  logic [PC_W-1:0] pc_q;

  logic            accept;
  logic            push, pop, full, empty;
  logic [7:0]      top_tier;
  logic [PC_W-1:0] top_pc;
  logic [SP_W-1:0] sp;

  logic            ex_ok;
  logic [31:0]     ex_cause;
  logic [7:0]      ex_tier;
  logic [PC_W-1:0] ex_pc;

  logic            rsp_valid_r;
  logic            rsp_ok_r;
  logic [PC_W-1:0] rsp_pc_r;
  logic [31:0]     rsp_cause_r;

  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_ok    = rsp_ok_r;
  assign bus.rsp_pc    = rsp_pc_r;
  assign bus.rsp_cause = rsp_cause_r;
  assign md_sp_o       = sp;

  carbon_mode_stack #(.DEPTH(DEPTH), .PC_W(PC_W)) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_tier (tier_o),
    .push_pc   (pc_q),
    .full      (full),
    .empty     (empty),
    .sp        (sp),
    .top_tier  (top_tier),
    .top_pc    (top_pc)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Request capture: fields are frozen on the accept edge only.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= carbon_md_op_e'(bus.req_op);
      tier_q <= bus.req_tier;
      pc_q   <= bus.req_ret_pc;
    end
  end

  // Next state and EXEC-cycle evaluation; faults leave tier and stack untouched.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    pop       = 1'b0;
    ex_ok     = 1'b0;
    ex_cause  = 32'h0;
    ex_tier   = tier_o;
    ex_pc     = '0;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: begin
        state_nxt = ST_RESP;
        if (op_q == MD_MODEUP) begin
          if ((tier_q <= tier_o) || (tier_q > 8'(MAX_TIER))) begin
            ex_cause = CARBON_CAUSE_MODEUP_INVALID;
          end else if (full) begin
            ex_cause = CARBON_CAUSE_MODESTACK_OVERFLOW;
          end else begin
            push    = 1'b1;
            ex_ok   = 1'b1;
            ex_tier = tier_q;
            ex_pc   = pc_q;
          end
        end else begin
          if (empty) begin
            ex_cause = CARBON_CAUSE_RETMD_UNDERFLOW;
          end else begin
            pop     = 1'b1;
            ex_ok   = 1'b1;
            ex_tier = top_tier;
            ex_pc   = top_pc;
          end
        end
      end
      ST_RESP: if (bus.rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Tier CSR and response registers: loaded at the end of EXEC, held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tier_o      <= 8'(RESET_TIER);
      rsp_valid_r <= 1'b0;
      rsp_ok_r    <= 1'b0;
      rsp_pc_r    <= '0;
      rsp_cause_r <= 32'h0;
    end else if (state == ST_EXEC) begin
      tier_o      <= ex_tier;
      rsp_valid_r <= 1'b1;
      rsp_ok_r    <= ex_ok;
      rsp_pc_r    <= ex_pc;
      rsp_cause_r <= ex_cause;
    end else if ((state == ST_RESP) && bus.rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

endmodule
